snake_body_engine: RTL and testbench

Parametrised snake position/body engine for the VGA snake game, generalising the fixed 20-segment snake datapath. It holds up to MAX_LEN segment coordinates on a GRID_W x GRID_H cell grid and advances one cell per TICK in the commanded direction. It also supports edge wrap or wall-death mode, blocks direction reversal, and detects self-collision and target capture. It answers a per-pixel "is this cell head/body" query from the colour-generation logic with fixed latency.

---
 rtl/snake_body_engine.sv | 204 ++++++++++++++++++++
 tb/tb_snake_body_engine.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/snake_body_engine.sv
// ============================================================================
// snake_body_engine : snake segment store, mover, collision/capture detect
//                     and registered per-cell head/body hit query.
// Revision: 1.0
// ============================================================================
`default_nettype none

module snake_body_engine #(
  parameter int MAX_LEN  = 32,
  parameter int INIT_LEN = 2,
  parameter int GRID_W   = 160,
  parameter int GRID_H   = 120,
  parameter int XW       = 8,
  parameter int YW       = 7,
  parameter int START_X  = 80,
  parameter int START_Y  = 100,
  parameter int WRAP     = 1,
  parameter int LW       = 6
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          CLEAR,
  input  logic          TICK,
  input  logic [1:0]    DIR,
  input  logic [XW-1:0] TARGET_X,
  input  logic [YW-1:0] TARGET_Y,
  input  logic [XW-1:0] QUERY_X,
  input  logic [YW-1:0] QUERY_Y,
  output logic          HIT_HEAD,
  output logic          HIT_BODY,
  output logic [XW-1:0] HEAD_X,
  output logic [YW-1:0] HEAD_Y,
  output logic [LW-1:0] LENGTH,
  output logic          TARGET_REACHED,
  output logic          COLLISION,
  output logic          FULL
);

  localparam logic [1:0]    DIR_UP    = 2'b00;
  localparam logic [1:0]    DIR_LEFT  = 2'b01;
  localparam logic [1:0]    DIR_RIGHT = 2'b10;
  localparam logic [1:0]    DIR_DOWN  = 2'b11;
  localparam logic          WRAP_EN   = (WRAP != 0);
  localparam logic [XW-1:0] X_MAX     = XW'(GRID_W - 1);
  localparam logic [YW-1:0] Y_MAX     = YW'(GRID_H - 1);
  localparam logic [XW-1:0] X_START   = XW'(START_X);
  localparam logic [YW-1:0] Y_START   = YW'(START_Y);
  localparam logic [LW-1:0] LEN_INIT  = LW'(INIT_LEN);
  localparam logic [LW-1:0] LEN_LAST  = LW'(MAX_LEN - 1);

  logic [XW-1:0] seg_x_q [MAX_LEN];
  logic [XW-1:0] seg_x_d [MAX_LEN];
  logic [YW-1:0] seg_y_q [MAX_LEN];
  logic [YW-1:0] seg_y_d [MAX_LEN];
  logic [LW-1:0] len_q, len_d;
  logic [1:0]    dir_q, dir_d;
  logic          collision_q, collision_d;
  logic          full_q, full_d;
  logic          reached_q, reached_d;
  logic          hit_head_q, hit_head_d;
  logic          hit_body_q, hit_body_d;

  logic [1:0]    dir_acc;
  logic [XW-1:0] next_x;
  logic [YW-1:0] next_y;
  logic          wall_hit;
  logic          self_hit;
  logic          eat;

  // Opposite directions are bitwise complements: 00/11 and 01/10.
  always_comb begin
    dir_acc  = (DIR == ~dir_q) ? dir_q : DIR;
    next_x   = seg_x_q[0];
    next_y   = seg_y_q[0];
    wall_hit = 1'b0;
    case (dir_acc)
      DIR_UP: begin
        if (seg_y_q[0] == '0) begin
          if (WRAP_EN) next_y = Y_MAX;
          else         wall_hit = 1'b1;
        end else next_y = seg_y_q[0] - YW'(1);
      end
      DIR_LEFT: begin
        if (seg_x_q[0] == '0) begin
          if (WRAP_EN) next_x = X_MAX;
          else         wall_hit = 1'b1;
        end else next_x = seg_x_q[0] - XW'(1);
      end
      DIR_RIGHT: begin
        if (seg_x_q[0] >= X_MAX) begin
          if (WRAP_EN) next_x = '0;
          else         wall_hit = 1'b1;
        end else next_x = seg_x_q[0] + XW'(1);
      end
      default: begin
        if (seg_y_q[0] >= Y_MAX) begin
          if (WRAP_EN) next_y = '0;
          else         wall_hit = 1'b1;
        end else next_y = seg_y_q[0] + YW'(1);
      end
    endcase
  end

  always_comb begin
    eat = !wall_hit && (next_x == TARGET_X) && (next_y == TARGET_Y) &&
          ({1'b0, TARGET_X} < (XW+1)'(GRID_W)) &&
          ({1'b0, TARGET_Y} < (YW+1)'(GRID_H));
    // The tail vacates its cell on a plain move, but stays put when eating.
    self_hit = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (((i < int'(len_q) - 1) || (eat && (i < int'(len_q)))) &&
          (seg_x_q[i] == next_x) && (seg_y_q[i] == next_y))
        self_hit = 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < MAX_LEN; i++) begin
      seg_x_d[i] = seg_x_q[i];
      seg_y_d[i] = seg_y_q[i];
    end
    len_d       = len_q;
    dir_d       = dir_q;
    collision_d = collision_q;
    full_d      = full_q;
    reached_d   = 1'b0;
    hit_head_d  = (QUERY_X == seg_x_q[0]) && (QUERY_Y == seg_y_q[0]);
    hit_body_d  = 1'b0;
    for (int i = 1; i < MAX_LEN; i++) begin
      if ((i < int'(len_q)) && (QUERY_X == seg_x_q[i]) && (QUERY_Y == seg_y_q[i]))
        hit_body_d = 1'b1;
    end

    if (CLEAR) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x_d[i] = X_START;
        seg_y_d[i] = Y_START;
      end
      len_d       = LEN_INIT;
      dir_d       = DIR_RIGHT;
      collision_d = 1'b0;
      full_d      = 1'b0;
      hit_head_d  = 1'b0;
      hit_body_d  = 1'b0;
    end else if (TICK && !collision_q && !full_q) begin
      dir_d = dir_acc;
      if (wall_hit || self_hit) begin
        collision_d = 1'b1;
      end else begin
        for (int i = 1; i < MAX_LEN; i++) begin
          seg_x_d[i] = seg_x_q[i-1];
          seg_y_d[i] = seg_y_q[i-1];
        end
        seg_x_d[0] = next_x;
        seg_y_d[0] = next_y;
        if (eat) begin
          len_d     = len_q + LW'(1);
          reached_d = 1'b1;
          if (len_q == LEN_LAST) full_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x_q[i] <= X_START;
        seg_y_q[i] <= Y_START;
      end
      len_q       <= LEN_INIT;
      dir_q       <= DIR_RIGHT;
      collision_q <= 1'b0;
      full_q      <= 1'b0;
      reached_q   <= 1'b0;
      hit_head_q  <= 1'b0;
      hit_body_q  <= 1'b0;
    end else begin
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x_q[i] <= seg_x_d[i];
        seg_y_q[i] <= seg_y_d[i];
      end
      len_q       <= len_d;
      dir_q       <= dir_d;
      collision_q <= collision_d;
      full_q      <= full_d;
      reached_q   <= reached_d;
      hit_head_q  <= hit_head_d;
      hit_body_q  <= hit_body_d;
    end
  end

  assign HIT_HEAD       = hit_head_q;
  assign HIT_BODY       = hit_body_q;
  assign HEAD_X         = seg_x_q[0];
  assign HEAD_Y         = seg_y_q[0];
  assign LENGTH         = len_q;
  assign TARGET_REACHED = reached_q;
  assign COLLISION      = collision_q;
  assign FULL           = full_q;

endmodule

`default_nettype wire

// File: tb/tb_snake_body_engine.sv
// ============================================================================
// tb_snake_body_engine : directed bench for snake_body_engine (three configs)
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_snake_body_engine;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       CLEAR = 1'b0;
  logic       TICK = 1'b0;
  logic [1:0] DIR = 2'b10;
  logic [7:0] TARGET_X = 8'd200;
  logic [6:0] TARGET_Y = 7'd0;
  logic [7:0] QUERY_X = 8'd0;
  logic [6:0] QUERY_Y = 7'd0;

  logic       a_hh, a_hb, a_tr, a_co, a_fu;
  logic [7:0] a_hx;
  logic [6:0] a_hy;
  logic [5:0] a_len;
  logic       n_hh, n_hb, n_tr, n_co, n_fu;
  logic [7:0] n_hx;
  logic [6:0] n_hy;
  logic [5:0] n_len;
  logic       s_hh, s_hb, s_tr, s_co, s_fu;
  logic [7:0] s_hx;
  logic [6:0] s_hy;
  logic [2:0] s_len;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  snake_body_engine u_dut (
    .CLK(CLK), .RESET(RESET), .CLEAR(CLEAR), .TICK(TICK), .DIR(DIR),
    .TARGET_X(TARGET_X), .TARGET_Y(TARGET_Y), .QUERY_X(QUERY_X), .QUERY_Y(QUERY_Y),
    .HIT_HEAD(a_hh), .HIT_BODY(a_hb), .HEAD_X(a_hx), .HEAD_Y(a_hy), .LENGTH(a_len),
    .TARGET_REACHED(a_tr), .COLLISION(a_co), .FULL(a_fu)
  );

  snake_body_engine #(.WRAP(0)) u_nowrap (
    .CLK(CLK), .RESET(RESET), .CLEAR(CLEAR), .TICK(TICK), .DIR(DIR),
    .TARGET_X(TARGET_X), .TARGET_Y(TARGET_Y), .QUERY_X(QUERY_X), .QUERY_Y(QUERY_Y),
    .HIT_HEAD(n_hh), .HIT_BODY(n_hb), .HEAD_X(n_hx), .HEAD_Y(n_hy), .LENGTH(n_len),
    .TARGET_REACHED(n_tr), .COLLISION(n_co), .FULL(n_fu)
  );

  snake_body_engine #(.MAX_LEN(4), .LW(3)) u_small (
    .CLK(CLK), .RESET(RESET), .CLEAR(CLEAR), .TICK(TICK), .DIR(DIR),
    .TARGET_X(TARGET_X), .TARGET_Y(TARGET_Y), .QUERY_X(QUERY_X), .QUERY_Y(QUERY_Y),
    .HIT_HEAD(s_hh), .HIT_BODY(s_hb), .HEAD_X(s_hx), .HEAD_Y(s_hy), .LENGTH(s_len),
    .TARGET_REACHED(s_tr), .COLLISION(s_co), .FULL(s_fu)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One TICK cycle; returns on the following falling edge with outputs settled.
  task automatic step(input logic [1:0] d);
    @(negedge CLK);
    DIR  = d;
    TICK = 1'b1;
    @(negedge CLK);
    TICK = 1'b0;
  endtask

  task automatic steps(input logic [1:0] d, input int n);
    for (int k = 0; k < n; k++) step(d);
  endtask

  task automatic query(input logic [7:0] x, input logic [6:0] y);
    @(negedge CLK);
    QUERY_X = x;
    QUERY_Y = y;
    @(negedge CLK);
  endtask

  task automatic clear_pulse();
    @(negedge CLK);
    CLEAR = 1'b1;
    @(negedge CLK);
    CLEAR = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge CLK);
    check("rst_hx", a_hx, 80);
    check("rst_hy", a_hy, 100);
    check("rst_len", a_len, 2);
    check("rst_col", a_co, 0);
    check("rst_full", a_fu, 0);
    check("rst_tr", a_tr, 0);
    check("rst_hh", a_hh, 0);
    check("rst_hb", a_hb, 0);
    RESET = 1'b0;

    // Straight run right, then body/head query with one-cycle latency.
    steps(2'b10, 3);
    check("run_hx", a_hx, 83);
    check("run_hy", a_hy, 100);
    check("run_len", a_len, 2);
    query(8'd82, 7'd100);
    check("q82_hb", a_hb, 1);
    check("q82_hh", a_hh, 0);
    query(8'd81, 7'd100);
    check("q81_hb", a_hb, 0);
    query(8'd83, 7'd100);
    check("q83_hh", a_hh, 1);

    // Reversal is rejected; perpendicular turn is accepted.
    step(2'b01);
    check("rev_hx", a_hx, 84);
    check("rev_hy", a_hy, 100);
    step(2'b00);
    check("up_hx", a_hx, 84);
    check("up_hy", a_hy, 99);

    // Walk to (159,50) and step right: wrap vs wall.
    steps(2'b00, 49);
    steps(2'b10, 75);
    check("edge_hx", a_hx, 159);
    check("edge_hy", a_hy, 50);
    check("edge_nw_hx", n_hx, 159);
    step(2'b10);
    check("wrap_hx", a_hx, 0);
    check("wrap_hy", a_hy, 50);
    check("wrap_col", a_co, 0);
    check("wall_col", n_co, 1);
    check("wall_hx", n_hx, 159);
    step(2'b10);
    check("wall_frozen_hx", n_hx, 159);

    // Restart and set up head (80,100) moving right with body at (79,100).
    clear_pulse();
    check("clr_hx", a_hx, 80);
    check("clr_hy", a_hy, 100);
    check("clr_nw_col", n_co, 0);
    step(2'b00);
    step(2'b01);
    step(2'b11);
    step(2'b10);
    check("setup_hx", a_hx, 80);
    check("setup_hy", a_hy, 100);
    TARGET_X = 8'd81;
    TARGET_Y = 7'd100;
    step(2'b10);
    check("eat_hx", a_hx, 81);
    check("eat_tr", a_tr, 1);
    check("eat_len", a_len, 3);
    @(negedge CLK);
    check("eat_tr_pulse", a_tr, 0);
    query(8'd79, 7'd100);
    check("tail_hb", a_hb, 1);

    // Small config reaches MAX_LEN=4 and freezes.
    TARGET_X = 8'd82;
    step(2'b10);
    check("s_len4", s_len, 4);
    check("s_full", s_fu, 1);
    check("s_tr", s_tr, 1);
    check("a_len4", a_len, 4);
    check("a_nofull", a_fu, 0);
    TARGET_X = 8'd83;
    step(2'b10);
    check("s_frozen_hx", s_hx, 82);
    check("s_frozen_len", s_len, 4);
    check("s_frozen_tr", s_tr, 0);
    check("a_len5", a_len, 5);
    check("a_hx83", a_hx, 83);

    // Length-5 U-turn bites its own body on the fourth tick.
    TARGET_X = 8'd200;
    TARGET_Y = 7'd0;
    step(2'b10);
    step(2'b11);
    step(2'b01);
    check("u3_col", a_co, 0);
    check("u3_hx", a_hx, 83);
    check("u3_hy", a_hy, 101);
    step(2'b00);
    check("u4_col", a_co, 1);
    check("u4_hx", a_hx, 83);
    check("u4_hy", a_hy, 101);
    step(2'b00);
    check("u5_hy", a_hy, 101);
    clear_pulse();
    check("clr2_hx", a_hx, 80);
    check("clr2_hy", a_hy, 100);
    check("clr2_len", a_len, 2);
    check("clr2_col", a_co, 0);
    check("clr2_s_full", s_fu, 0);
    check("clr2_s_len", s_len, 2);

    // Asynchronous reset while TICK is still high.
    TARGET_X = 8'd81;
    TARGET_Y = 7'd100;
    @(negedge CLK);
    DIR  = 2'b10;
    TICK = 1'b1;
    @(posedge CLK);
    #1;
    check("pre_rst_tr", a_tr, 1);
    check("pre_rst_len", a_len, 3);
    RESET = 1'b1;
    #1;
    check("arst_len", a_len, 2);
    check("arst_hx", a_hx, 80);
    check("arst_tr", a_tr, 0);
    check("arst_s_len", s_len, 2);
    TICK = 1'b0;
    @(negedge CLK);
    RESET = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
